uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` transmitter among `N_REQ` byte-producing requesters. It latches the winning requester's byte and drives the transmitter's `enable`/`start`/`data_in`. It then waits for the transmitter's `done` pulse and returns a one-cycle acknowledge to the winner. It sits between the system's message sources (status, debug, command-response paths) and the single UART TX instance, and includes a watchdog against a hung transmitter.

---
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the UART TX arbiter
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
  logic arb_en;
  logic [N_REQ-1:0] req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0] ack;
  logic [N_REQ-1:0] err;
  logic busy;
  logic [2:0] active_id;
  logic tx_enable;
  logic tx_start;
  logic [7:0] tx_data;
  logic tx_done;
  logic tx_busy;
  modport master (
    input arb_en, req, req_data, tx_done, tx_busy,
    output ack, err, busy, active_id, tx_enable, tx_start, tx_data
  );
  modport slave (
    output arb_en, req, req_data, tx_done, tx_busy,
    input ack, err, busy, active_id, tx_enable, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N_REQ byte requesters, with a done watchdog
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int TIMEOUT = 2047
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.master bus
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [2:0] {IDLE = 3'd0, LAUNCH = 3'd1, WAIT = 3'd2, DONE = 3'd3, ABORT = 3'd4} state_t;
  state_t state, nxt;
  logic [2:0] ptr, ptr_d, win, wrap, id_d;
  logic [IW-1:0] idx;
  logic [15:0] cnt, cnt_d;
  logic [N_REQ-1:0] ack_d, err_d, onehot;
  logic busy_d, en_d, start_d, grant;
  logic [7:0] data_d;
  assign grant = bus.arb_en && |bus.req && !bus.tx_busy && !bus.tx_done;
  assign wrap = (int'(bus.active_id) == N_REQ - 1) ? 3'd0 : bus.active_id + 3'd1;
  assign onehot = N_REQ'(1) << bus.active_id;
  // walk downward so the index closest to ptr is the last (winning) assignment
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N_REQ);
      if (bus.req[idx]) win = 3'(idx);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      bus.ack <= '0;
      bus.err <= '0;
      bus.busy <= 1'b0;
      bus.active_id <= '0;
      bus.tx_enable <= 1'b0;
      bus.tx_start <= 1'b0;
      bus.tx_data <= '0;
    end else begin
      state <= nxt;
      ptr <= ptr_d;
      cnt <= cnt_d;
      bus.ack <= ack_d;
      bus.err <= err_d;
      bus.busy <= busy_d;
      bus.active_id <= id_d;
      bus.tx_enable <= en_d;
      bus.tx_start <= start_d;
      bus.tx_data <= data_d;
    end
  end
  always_comb begin
    case (state)
      IDLE: nxt = grant ? LAUNCH : IDLE;
      LAUNCH: nxt = WAIT;
      WAIT: nxt = bus.tx_done ? DONE : (cnt == 16'(TIMEOUT)) ? ABORT : WAIT;
      default: nxt = IDLE;
    endcase
  end
  // next values of the registered outputs; tx_enable holds between frames
  always_comb begin
    ack_d = '0;
    err_d = '0;
    start_d = (state == LAUNCH);
    en_d = bus.tx_enable;
    busy_d = bus.busy;
    id_d = bus.active_id;
    data_d = bus.tx_data;
    ptr_d = ptr;
    cnt_d = cnt;
    case (state)
      IDLE: if (grant) begin
        id_d = win;
        data_d = bus.req_data[8*win +: 8];
        busy_d = 1'b1;
      end
      LAUNCH: begin
        en_d = 1'b1;
        cnt_d = '0;
      end
      WAIT: begin
        en_d = 1'b1;
        cnt_d = cnt + 16'd1;
      end
      DONE: begin
        ack_d = onehot;
        ptr_d = wrap;
        busy_d = 1'b0;
      end
      ABORT: begin
        err_d = onehot;
        en_d = 1'b0;
        ptr_d = wrap;
        busy_d = 1'b0;
      end
      default: begin
        en_d = 1'b0;
        busy_d = 1'b0;
        id_d = '0;
        data_d = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scenarios checked against a rotating-priority reference model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0, n_bad = 0, n_start = 0, n_ack = 0, mptr = 0;
  uart_tx_arbiter_if #(.N_REQ(N)) bus();
  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.tx_start) n_start++;
    if (|bus.ack) n_ack++;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // plays the transmitter: waits for tx_start, raises tx_done dly cycles later (never if dly < 0)
  task automatic do_frame(input int dly, output int ts, output logic [7:0] d, output logic [2:0] id,
                          output logic en, output int lat, output logic [3:0] a, output logic [3:0] e);
    ts = -1; lat = -1; a = '0; e = '0; d = '0; id = '0; en = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.tx_start) begin ts = c; break; end
    end
    if (ts < 0) return;
    d = bus.tx_data; id = bus.active_id; en = bus.tx_enable;
    for (int c = 0; c < 60; c++) begin
      bus.tx_done = (c == dly);
      tick();
      if (|bus.ack || |bus.err) begin lat = c + 1; a = bus.ack; e = bus.err; break; end
    end
    bus.tx_done = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; bus.arb_en = 1'b0; bus.req = '0; bus.req_data = '0; bus.tx_done = 1'b0; bus.tx_busy = 1'b0;
    repeat (3) tick();
    n_cmp++; if ({bus.ack, bus.err, bus.busy, bus.active_id, bus.tx_enable, bus.tx_start, bus.tx_data} !== '0) begin n_bad++; $display("FAIL reset_outputs: got ack=%b err=%b busy=%b id=%0d en=%b start=%b data=%h, expected all 0", bus.ack, bus.err, bus.busy, bus.active_id, bus.tx_enable, bus.tx_start, bus.tx_data); end
    rst = 1'b0; bus.arb_en = 1'b1; mptr = 0;
    repeat (2) tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_req_busy: got %b expected 0", bus.busy); end
  endtask
  task automatic test_single();
    int ts, lat, s0, dly;
    logic [7:0] d; logic [2:0] id; logic en; logic [3:0] a, e;
    dly = int'($urandom_range(0, 8));
    bus.req_data = $urandom(); bus.req_data[23:16] = 8'hA5; bus.req = 4'b0100; s0 = n_start;
    do_frame(dly, ts, d, id, en, lat, a, e);
    n_cmp++; if (ts !== 2) begin n_bad++; $display("FAIL single_start_latency: got %0d expected 2", ts); end
    n_cmp++; if (d !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h expected a5", d); end
    n_cmp++; if (int'(id) !== pick(mptr, 4'b0100)) begin n_bad++; $display("FAIL single_id: got %0d expected 2", id); end
    n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL single_enable: got %b expected 1", en); end
    n_cmp++; if (a !== 4'b0100 || e !== 4'b0000) begin n_bad++; $display("FAIL single_ack: got ack=%b err=%b expected ack=0100 err=0000", a, e); end
    n_cmp++; if (lat !== dly + 2) begin n_bad++; $display("FAIL single_ack_latency: got %0d expected %0d", lat, dly + 2); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_at_ack: got %b expected 0", bus.busy); end
    bus.req = '0; mptr = 3;
    tick();
    n_cmp++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL single_start_count: got %0d expected 1", n_start - s0); end
  endtask
  task automatic test_round_robin();
    int ts, lat, s0, a0, ex;
    logic [7:0] d; logic [2:0] id; logic en; logic [3:0] a, e;
    rst = 1'b1; tick(); rst = 1'b0; mptr = 0;
    bus.req_data = 32'h13121110; bus.req = 4'b1111; s0 = n_start; a0 = n_ack;
    for (int f = 0; f < 5; f++) begin
      ex = pick(mptr, 4'b1111);
      do_frame(int'($urandom_range(0, 10)), ts, d, id, en, lat, a, e);
      n_cmp++; if (int'(id) !== ex || d !== 8'(8'h10 + ex) || ts !== 2) begin n_bad++; $display("FAIL rr_frame%0d: got id=%0d data=%h gap=%0d expected id=%0d data=%h gap=2", f, id, d, ts, ex, 8'(8'h10 + ex)); end
      n_cmp++; if (a !== 4'(1 << ex) || e !== '0) begin n_bad++; $display("FAIL rr_ack%0d: got ack=%b err=%b expected ack=%b", f, a, e, 4'(1 << ex)); end
      mptr = (ex + 1) % N;
    end
    bus.req = '0;
    repeat (3) tick();
    n_cmp++; if (n_start - s0 !== 5 || n_ack - a0 !== 5) begin n_bad++; $display("FAIL rr_counts: got starts=%0d acks=%0d expected 5/5", n_start - s0, n_ack - a0); end
  endtask
  task automatic test_timeout();
    int ts, lat, ex;
    logic [7:0] d; logic [2:0] id; logic en; logic [3:0] a, e;
    bus.req_data = $urandom(); bus.req = 4'b0001; ex = pick(mptr, 4'b0001);
    do_frame(-1, ts, d, id, en, lat, a, e);
    n_cmp++; if (lat !== TO + 2 || e !== 4'b0001 || a !== '0) begin n_bad++; $display("FAIL timeout_err: got lat=%0d err=%b ack=%b expected lat=%0d err=0001 ack=0000", lat, e, a, TO + 2); end
    n_cmp++; if (bus.tx_enable !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL timeout_abort_outputs: got en=%b busy=%b expected 0/0", bus.tx_enable, bus.busy); end
    bus.req = '0; mptr = (ex + 1) % N;
    tick();
    n_cmp++; if (bus.tx_enable !== 1'b0) begin n_bad++; $display("FAIL timeout_enable_after: got %b expected 0", bus.tx_enable); end
    bus.req = 4'b1111; ex = pick(mptr, 4'b1111);
    do_frame(int'($urandom_range(0, 6)), ts, d, id, en, lat, a, e);
    n_cmp++; if (int'(id) !== ex || en !== 1'b1 || a !== 4'(1 << ex)) begin n_bad++; $display("FAIL timeout_ptr_advance: got id=%0d en=%b ack=%b expected id=%0d en=1", id, en, a, ex); end
    bus.req = '0; mptr = (ex + 1) % N;
  endtask
  task automatic test_gating();
    int ts, lat;
    logic [7:0] d; logic [2:0] id; logic en; logic [3:0] a, e;
    logic seen;
    tick();
    bus.arb_en = 1'b0; bus.req = 4'b0010; bus.req_data = $urandom(); seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= bus.tx_start | bus.busy; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL gate_arb_en: got activity=%b expected 0", seen); end
    bus.arb_en = 1'b1; bus.tx_busy = 1'b1; seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= bus.tx_start | bus.busy; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL gate_tx_busy: got activity=%b expected 0", seen); end
    bus.tx_busy = 1'b0; bus.tx_done = 1'b1;
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL gate_tx_done_idle: got busy=%b expected 0", bus.busy); end
    bus.tx_done = 1'b0;
    do_frame(int'($urandom_range(0, 6)), ts, d, id, en, lat, a, e);
    n_cmp++; if (ts !== 2 || int'(id) !== pick(mptr, 4'b0010) || d !== bus.req_data[15:8]) begin n_bad++; $display("FAIL gate_release_grant: got latency=%0d id=%0d data=%h expected 2/1/%h", ts, id, d, bus.req_data[15:8]); end
    bus.req = '0; mptr = 2;
  endtask
  task automatic test_mid_frame();
    int lane, got;
    logic [7:0] b; logic [31:0] rd;
    lane = int'($urandom_range(0, 3)); b = 8'($urandom_range(0, 254)); got = 0;
    rd = $urandom(); rd[8*lane +: 8] = b;
    bus.req_data = rd; bus.req = 4'(1 << lane);
    for (int c = 0; c < 40 && got == 0; c++) begin tick(); if (bus.tx_start) got = 1; end
    n_cmp++; if (got !== 1) begin n_bad++; $display("FAIL mid_start_seen: got %0d expected 1", got); end
    repeat (2) tick();
    bus.req = '0; rd[8*lane +: 8] = 8'hFF; bus.req_data = rd; bus.arb_en = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.tx_data !== b || bus.tx_enable !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_hold: got data=%h en=%b busy=%b expected %h/1/1", bus.tx_data, bus.tx_enable, bus.busy, b); end
    bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0; tick();
    n_cmp++; if (bus.ack !== 4'(1 << lane) || bus.err !== '0) begin n_bad++; $display("FAIL mid_ack: got ack=%b err=%b expected ack=%b", bus.ack, bus.err, 4'(1 << lane)); end
    bus.arb_en = 1'b1; mptr = (lane + 1) % N;
  endtask
  task automatic test_reset_mid();
    int ts, lat, got;
    logic [7:0] d; logic [2:0] id; logic en; logic [3:0] a, e;
    got = 0; bus.req = 4'b1111; bus.req_data = $urandom();
    for (int c = 0; c < 40 && got == 0; c++) begin tick(); if (bus.tx_start) got = 1; end
    repeat (3) tick();
    rst = 1'b1; tick();
    n_cmp++; if ({bus.ack, bus.err, bus.busy, bus.active_id, bus.tx_enable, bus.tx_start, bus.tx_data} !== '0 || got !== 1) begin n_bad++; $display("FAIL reset_mid_outputs: got busy=%b id=%0d en=%b data=%h started=%0d expected all 0 after start", bus.busy, bus.active_id, bus.tx_enable, bus.tx_data, got); end
    rst = 1'b0; mptr = 0;
    do_frame(int'($urandom_range(0, 6)), ts, d, id, en, lat, a, e);
    n_cmp++; if (ts !== 2 || int'(id) !== pick(mptr, 4'b1111)) begin n_bad++; $display("FAIL reset_mid_regrant: got latency=%0d id=%0d expected 2/0", ts, id); end
    bus.req = '0; mptr = 1;
  endtask
  task automatic test_simultaneous();
    int ts, lat, ex;
    logic [7:0] d; logic [2:0] id; logic en; logic [3:0] a, e, r;
    r = 4'($urandom_range(1, 15)); ex = pick(mptr, r);
    bus.req = r; bus.req_data = $urandom();
    do_frame(TO, ts, d, id, en, lat, a, e);
    n_cmp++; if (a !== 4'(1 << ex) || e !== '0 || lat !== TO + 2) begin n_bad++; $display("FAIL done_vs_timeout: got ack=%b err=%b lat=%0d expected ack=%b err=0000 lat=%0d", a, e, lat, 4'(1 << ex), TO + 2); end
    bus.req = '0; mptr = (ex + 1) % N;
  endtask
  task automatic test_random();
    int ts, lat, ex, dly;
    logic [7:0] d; logic [2:0] id; logic en; logic [3:0] a, e, r;
    logic [31:0] rd;
    for (int f = 0; f < 24; f++) begin
      r = 4'($urandom_range(1, 15)); rd = $urandom(); dly = int'($urandom_range(0, 12));
      bus.req = r; bus.req_data = rd; ex = pick(mptr, r);
      do_frame(dly, ts, d, id, en, lat, a, e);
      n_cmp++; if (int'(id) !== ex || d !== 8'(rd >> (8 * ex)) || ts !== 2 || lat !== dly + 2 || a !== 4'(1 << ex) || e !== '0) begin n_bad++; $display("FAIL random%0d: got id=%0d data=%h gap=%0d lat=%0d ack=%b err=%b expected id=%0d data=%h gap=2 lat=%0d ack=%b", f, id, d, ts, lat, a, e, ex, 8'(rd >> (8 * ex)), dly + 2, 4'(1 << ex)); end
      mptr = (ex + 1) % N;
    end
    bus.req = '0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_gating();
    test_mid_frame();
    test_reset_mid();
    test_simultaneous();
    test_random();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
